// File: rtl/xbus_lsu_pkg.sv
// Shared constants and types for the XBUS load/store unit.
package xbus_lsu_pkg;

  // Access length, carried in funct3[1:0].
  localparam logic [1:0] ML_BYTE   = 2'b00;
  localparam logic [1:0] ML_HALF   = 2'b01;
  localparam logic [1:0] ML_WORD   = 2'b10;
  localparam logic [1:0] ML_DOUBLE = 2'b11;

  // Extension mode, carried in funct3[2].
  localparam logic MS_SIGN   = 1'b0;
  localparam logic MS_UNSIGN = 1'b1;

  // Sequencer states.
  typedef enum logic [1:0] {
    LSU_IDLE  = 2'd0,
    LSU_BEAT0 = 2'd1,
    LSU_BEAT1 = 2'd2,
    LSU_RESP  = 2'd3
  } lsu_state_e;

  // Number of bytes touched by an access of the given length.
  function automatic logic [3:0] len_bytes(input logic [1:0] len);
    return 4'd1 << len;
  endfunction

endpackage

// File: rtl/xbus_lane_align.sv
// Combinational lane steering: byte enables and store data for both bus
// beats, plus load-data assembly and extension from the two captured beats.
module xbus_lane_align
  import xbus_lsu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [$clog2(XLEN/8)-1:0] offset,
  input  logic [1:0]                len,
  input  logic                      sign_mode,
  input  logic [XLEN-1:0]           wdata,
  input  logic [XLEN-1:0]           rdata0,
  input  logic [XLEN-1:0]           rdata1,
  output logic [XLEN/8-1:0]         be0,
  output logic [XLEN/8-1:0]         be1,
  output logic [XLEN-1:0]           wdata0,
  output logic [XLEN-1:0]           wdata1,
  output logic [XLEN-1:0]           load_data
);

  localparam int NB = XLEN / 8;
  localparam int OW = $clog2(NB);

  logic [OW+2:0]     shamt;
  logic [3:0]        nbytes;
  logic              uns;
  logic [2*NB-1:0]   size_mask;
  logic [2*NB-1:0]   lane_mask;
  logic [2*XLEN-1:0] wide_wdata;
  logic [XLEN-1:0]   low;
  logic [XLEN-1:0]   word_ext;

  assign shamt  = {offset, 3'b000};
  assign nbytes = len_bytes(len);
  assign uns    = (sign_mode == MS_UNSIGN);

  // Contiguous mask for the access size, before it is moved to its lanes.
  for (genvar gi = 0; gi < 2 * NB; gi++) begin : g_size_mask
    assign size_mask[gi] = (gi < int'(nbytes));
  end

  // Lanes past the top of the bus word spill into the second beat.
  assign lane_mask = size_mask << offset;
  assign be0       = lane_mask[NB-1:0];
  assign be1       = lane_mask[2*NB-1:NB];

  // Store data shifted across a double-width window; upper half feeds beat1.
  assign wide_wdata = {{XLEN{1'b0}}, wdata} << shamt;
  assign wdata0     = wide_wdata[XLEN-1:0];
  assign wdata1     = wide_wdata[2*XLEN-1:XLEN];

  // Bring the addressed bytes down to bit 0 from the {beat1, beat0} pair.
  assign low = XLEN'({rdata1, rdata0} >> shamt);

  // A word only needs extending when the register is wider than a word.
  if (XLEN > 32) begin : g_word_ext
    logic word_sign;
    assign word_sign = ~uns & low[31];
    assign word_ext  = {{(XLEN-32){word_sign}}, low[31:0]};
  end else begin : g_word_raw
    assign word_ext = low;
  end

  // Mask to the access size and extend the sign unless unsigned.
  always_comb begin
    load_data = low;
    case (len)
      ML_BYTE: load_data = {{(XLEN-8){~uns & low[7]}}, low[7:0]};
      ML_HALF: load_data = {{(XLEN-16){~uns & low[15]}}, low[15:0]};
      ML_WORD: load_data = word_ext;
      default: load_data = low;
    endcase
  end

endmodule

// File: rtl/xbus_lsu.sv
// Sequential load/store unit: accepts one core access at a time, issues one
// or two aligned XBUS beats, and returns a single completion pulse.
module xbus_lsu
  import xbus_lsu_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter bit ALLOW_MISALIGN = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [31:0]       req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  output logic              resp_valid,
  output logic              resp_err,
  output logic [XLEN-1:0]   resp_rdata,
  output logic              xbus_req,
  output logic              xbus_we,
  output logic [XLEN/8-1:0] xbus_be,
  output logic [31:0]       xbus_addr,
  output logic [XLEN-1:0]   xbus_wdata,
  input  logic [XLEN-1:0]   xbus_rdata,
  input  logic              xbus_ack,
  input  logic              xbus_err
);

  localparam int NB = XLEN / 8;
  localparam int OW = $clog2(NB);

  lsu_state_e state_reg, state_next;

  // Latched request.
  logic            we_reg,     we_next;
  logic [1:0]      len_reg,    len_next;
  logic            sign_reg,   sign_next;
  logic [OW-1:0]   off_reg,    off_next;
  logic [XLEN-1:0] wdata_reg,  wdata_next;
  logic            split_reg,  split_next;
  logic [XLEN-1:0] rdata0_reg, rdata0_next;

  // Registered outputs.
  logic            resp_valid_reg, resp_valid_next;
  logic            resp_err_reg,   resp_err_next;
  logic [XLEN-1:0] resp_rdata_reg, resp_rdata_next;
  logic            xbus_req_reg,   xbus_req_next;
  logic            xbus_we_reg,    xbus_we_next;
  logic [NB-1:0]   xbus_be_reg,    xbus_be_next;
  logic [31:0]     xbus_addr_reg,  xbus_addr_next;
  logic [XLEN-1:0] xbus_wdata_reg, xbus_wdata_next;

  // Aligner inputs and results.
  logic            idle;
  logic [OW-1:0]   al_off;
  logic [1:0]      al_len;
  logic            al_sign;
  logic [XLEN-1:0] al_wdata;
  logic [XLEN-1:0] al_rdata0;
  logic [XLEN-1:0] al_rdata1;
  logic [NB-1:0]   be0, be1;
  logic [XLEN-1:0] wd0, wd1;
  logic [XLEN-1:0] load_data;

  logic            illegal_len;
  logic            req_split;
  logic            finish;
  logic            finish_err;

  assign idle = (state_reg == LSU_IDLE);

  // In IDLE the aligner looks at the incoming request so beat0 can be
  // registered on the accept edge; afterwards it works from the latches.
  assign al_off    = idle ? req_addr[OW-1:0]  : off_reg;
  assign al_len    = idle ? req_funct3[1:0]   : len_reg;
  assign al_sign   = idle ? req_funct3[2]     : sign_reg;
  assign al_wdata  = idle ? req_wdata         : wdata_reg;
  assign al_rdata0 = (state_reg == LSU_BEAT0) ? xbus_rdata : rdata0_reg;
  assign al_rdata1 = (state_reg == LSU_BEAT1) ? xbus_rdata : '0;

  xbus_lane_align #(
    .XLEN (XLEN)
  ) u_align (
    .offset    (al_off),
    .len       (al_len),
    .sign_mode (al_sign),
    .wdata     (al_wdata),
    .rdata0    (al_rdata0),
    .rdata1    (al_rdata1),
    .be0       (be0),
    .be1       (be1),
    .wdata0    (wd0),
    .wdata1    (wd1),
    .load_data (load_data)
  );

  // Any lane landing in the next bus word means a second beat is needed.
  assign req_split   = |be1;
  assign illegal_len = (req_funct3[1:0] == ML_DOUBLE) && (XLEN < 64);

  // Next state, request latches and registered bus/response outputs.
  always_comb begin
    state_next      = state_reg;
    we_next         = we_reg;
    len_next        = len_reg;
    sign_next       = sign_reg;
    off_next        = off_reg;
    wdata_next      = wdata_reg;
    split_next      = split_reg;
    rdata0_next     = rdata0_reg;
    resp_valid_next = 1'b0;
    resp_err_next   = 1'b0;
    resp_rdata_next = '0;
    xbus_req_next   = xbus_req_reg;
    xbus_we_next    = xbus_we_reg;
    xbus_be_next    = xbus_be_reg;
    xbus_addr_next  = xbus_addr_reg;
    xbus_wdata_next = xbus_wdata_reg;
    finish          = 1'b0;
    finish_err      = 1'b0;

    case (state_reg)
      LSU_IDLE: begin
        if (req_valid) begin
          we_next    = req_we;
          len_next   = req_funct3[1:0];
          sign_next  = req_funct3[2];
          off_next   = req_addr[OW-1:0];
          wdata_next = req_wdata;
          split_next = req_split;
          if (illegal_len || (req_split && !ALLOW_MISALIGN)) begin
            state_next      = LSU_RESP;
            resp_valid_next = 1'b1;
            resp_err_next   = 1'b1;
          end else begin
            state_next      = LSU_BEAT0;
            xbus_req_next   = 1'b1;
            xbus_we_next    = req_we;
            xbus_be_next    = be0;
            xbus_addr_next  = {req_addr[31:OW], {OW{1'b0}}};
            xbus_wdata_next = req_we ? wd0 : '0;
          end
        end
      end
      LSU_BEAT0: begin
        if (xbus_ack) begin
          if (xbus_err || !split_reg) begin
            finish     = 1'b1;
            finish_err = xbus_err;
          end else begin
            state_next      = LSU_BEAT1;
            rdata0_next     = xbus_rdata;
            xbus_be_next    = be1;
            xbus_addr_next  = xbus_addr_reg + 32'(NB);
            xbus_wdata_next = we_reg ? wd1 : '0;
          end
        end
      end
      LSU_BEAT1: begin
        if (xbus_ack) begin
          finish     = 1'b1;
          finish_err = xbus_err;
        end
      end
      default: begin
        state_next = LSU_IDLE;
      end
    endcase

    if (finish) begin
      state_next      = LSU_RESP;
      resp_valid_next = 1'b1;
      resp_err_next   = finish_err;
      resp_rdata_next = (we_reg || finish_err) ? '0 : load_data;
      xbus_req_next   = 1'b0;
      xbus_we_next    = 1'b0;
      xbus_be_next    = '0;
      xbus_addr_next  = '0;
      xbus_wdata_next = '0;
    end
  end

  // State and output registers; reset abandons any in-flight beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= LSU_IDLE;
      we_reg         <= 1'b0;
      len_reg        <= ML_BYTE;
      sign_reg       <= MS_SIGN;
      off_reg        <= '0;
      wdata_reg      <= '0;
      split_reg      <= 1'b0;
      rdata0_reg     <= '0;
      resp_valid_reg <= 1'b0;
      resp_err_reg   <= 1'b0;
      resp_rdata_reg <= '0;
      xbus_req_reg   <= 1'b0;
      xbus_we_reg    <= 1'b0;
      xbus_be_reg    <= '0;
      xbus_addr_reg  <= '0;
      xbus_wdata_reg <= '0;
    end else begin
      state_reg      <= state_next;
      we_reg         <= we_next;
      len_reg        <= len_next;
      sign_reg       <= sign_next;
      off_reg        <= off_next;
      wdata_reg      <= wdata_next;
      split_reg      <= split_next;
      rdata0_reg     <= rdata0_next;
      resp_valid_reg <= resp_valid_next;
      resp_err_reg   <= resp_err_next;
      resp_rdata_reg <= resp_rdata_next;
      xbus_req_reg   <= xbus_req_next;
      xbus_we_reg    <= xbus_we_next;
      xbus_be_reg    <= xbus_be_next;
      xbus_addr_reg  <= xbus_addr_next;
      xbus_wdata_reg <= xbus_wdata_next;
    end
  end

  assign req_ready  = idle;
  assign resp_valid = resp_valid_reg;
  assign resp_err   = resp_err_reg;
  assign resp_rdata = resp_rdata_reg;
  assign xbus_req   = xbus_req_reg;
  assign xbus_we    = xbus_we_reg;
  assign xbus_be    = xbus_be_reg;
  assign xbus_addr  = xbus_addr_reg;
  assign xbus_wdata = xbus_wdata_reg;

endmodule

// File: tb/tb_xbus_lsu.sv
// Scoreboard bench for xbus_lsu at XLEN=32: one unit splits misaligned
// accesses, a second one rejects them.
module tb_xbus_lsu;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  // Shared request payload, separate valids.
  logic        req_valid_a = 1'b0, req_valid_b = 1'b0;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'b0;
  logic [31:0] req_addr = 32'h0, req_wdata = 32'h0;

  logic        req_ready_a, resp_valid_a, resp_err_a;
  logic [31:0] resp_rdata_a;
  logic        xbus_req_a, xbus_we_a;
  logic [3:0]  xbus_be_a;
  logic [31:0] xbus_addr_a, xbus_wdata_a;
  logic [31:0] xbus_rdata_a = 32'h0;
  logic        xbus_ack_a = 1'b0, xbus_err_a = 1'b0;

  logic        req_ready_b, resp_valid_b, resp_err_b;
  logic [31:0] resp_rdata_b;
  logic        xbus_req_b, xbus_we_b;
  logic [3:0]  xbus_be_b;
  logic [31:0] xbus_addr_b, xbus_wdata_b;
  logic [31:0] xbus_rdata_b;
  logic        xbus_ack_b, xbus_err_b;

  // The rejecting unit sees a bus that always acks at once with fixed data.
  assign xbus_ack_b   = xbus_req_b;
  assign xbus_err_b   = 1'b0;
  assign xbus_rdata_b = 32'h12345678;

  xbus_lsu #(.XLEN(32), .ALLOW_MISALIGN(1'b1)) dut_a (
    .clk(clk), .rst(rst),
    .req_valid(req_valid_a), .req_ready(req_ready_a), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid_a), .resp_err(resp_err_a), .resp_rdata(resp_rdata_a),
    .xbus_req(xbus_req_a), .xbus_we(xbus_we_a), .xbus_be(xbus_be_a),
    .xbus_addr(xbus_addr_a), .xbus_wdata(xbus_wdata_a),
    .xbus_rdata(xbus_rdata_a), .xbus_ack(xbus_ack_a), .xbus_err(xbus_err_a)
  );

  xbus_lsu #(.XLEN(32), .ALLOW_MISALIGN(1'b0)) dut_b (
    .clk(clk), .rst(rst),
    .req_valid(req_valid_b), .req_ready(req_ready_b), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid_b), .resp_err(resp_err_b), .resp_rdata(resp_rdata_b),
    .xbus_req(xbus_req_b), .xbus_we(xbus_we_b), .xbus_be(xbus_be_b),
    .xbus_addr(xbus_addr_b), .xbus_wdata(xbus_wdata_b),
    .xbus_rdata(xbus_rdata_b), .xbus_ack(xbus_ack_b), .xbus_err(xbus_err_b)
  );

  typedef struct {
    int          cyc;
    logic [31:0] rdata;
    logic        err;
    string       name;
  } exp_t;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  be;
    logic        we;
    logic [31:0] wdata;
    int          waits;
    logic [31:0] rdata;
    logic        err;
  } beat_t;

  exp_t  exp_a[$];
  exp_t  exp_b[$];
  beat_t beat_q[$];
  int    breq_b_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic push_beat(input logic [31:0] addr, input logic [3:0] be, input logic we,
                           input logic [31:0] wdata, input int waits,
                           input logic [31:0] rdata, input logic err);
    beat_t b;
    b.addr = addr; b.be = be; b.we = we; b.wdata = wdata;
    b.waits = waits; b.rdata = rdata; b.err = err;
    beat_q.push_back(b);
  endtask

  // Present one request; lat < 0 means no response is expected.
  task automatic issue(input bit on_b, input logic we, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wdata, input int lat,
                       input logic [31:0] erd, input logic eerr, input string name);
    int   guard;
    exp_t e;
    guard = 0;
    @(negedge clk);
    while (!(on_b ? req_ready_b : req_ready_a) && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) begin
      tests++;
      fails++;
      $display("[TB] FAIL %s_ready: req_ready=0 after 50 cycles, expected 1", name);
    end
    req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
    if (on_b) req_valid_b = 1'b1;
    else      req_valid_a = 1'b1;
    if (lat >= 0) begin
      e.cyc = cyc + lat; e.rdata = erd; e.err = eerr; e.name = name;
      if (on_b) exp_b.push_back(e);
      else      exp_a.push_back(e);
    end
    $display("[TB] issue %s on %s we=%0d f3=%03b addr=%08h wdata=%08h", name,
             on_b ? "b" : "a", we, f3, addr, wdata);
    @(negedge clk);
    req_valid_a = 1'b0;
    req_valid_b = 1'b0;
  endtask

  // Response monitors: pop the oldest expectation whenever a unit completes.
  always @(negedge clk) begin : mon_a
    exp_t e;
    if (!rst && resp_valid_a) begin
      if (exp_a.size() == 0) begin
        tests++; fails++;
        $display("[TB] FAIL unexpected_resp_a: got resp at cycle %0d, expected none", cyc);
      end else begin
        e = exp_a.pop_front();
        $display("[TB] resp a %s cyc=%0d rdata=%08h err=%0d", e.name, cyc, resp_rdata_a, resp_err_a);
        check({e.name, "_cycle"}, 32'(cyc), 32'(e.cyc));
        check({e.name, "_rdata"}, resp_rdata_a, e.rdata);
        check({e.name, "_err"}, {31'b0, resp_err_a}, {31'b0, e.err});
      end
    end
  end

  always @(negedge clk) begin : mon_b
    exp_t e;
    if (!rst && xbus_req_b) breq_b_cnt++;
    if (!rst && resp_valid_b) begin
      if (exp_b.size() == 0) begin
        tests++; fails++;
        $display("[TB] FAIL unexpected_resp_b: got resp at cycle %0d, expected none", cyc);
      end else begin
        e = exp_b.pop_front();
        $display("[TB] resp b %s cyc=%0d rdata=%08h err=%0d", e.name, cyc, resp_rdata_b, resp_err_b);
        check({e.name, "_cycle"}, 32'(cyc), 32'(e.cyc));
        check({e.name, "_rdata"}, resp_rdata_b, e.rdata);
        check({e.name, "_err"}, {31'b0, resp_err_b}, {31'b0, e.err});
      end
    end
  end

  // Bus slave for unit a: checks each beat payload, then acks after its waits.
  initial begin : bus_a
    bit    busy;
    int    wcnt;
    beat_t cur;
    busy = 1'b0;
    wcnt = 0;
    forever begin
      @(negedge clk);
      xbus_ack_a   = 1'b0;
      xbus_err_a   = 1'b0;
      xbus_rdata_a = 32'h0;
      if (!xbus_req_a) begin
        busy = 1'b0;
      end else begin
        if (!busy) begin
          if (beat_q.size() == 0) begin
            tests++; fails++;
            $display("[TB] FAIL unexpected_beat: got beat addr=%08h be=%04b, expected none",
                     xbus_addr_a, xbus_be_a);
          end else begin
            cur  = beat_q.pop_front();
            busy = 1'b1;
            wcnt = 0;
            $display("[TB] beat cyc=%0d addr=%08h be=%04b we=%0d wdata=%08h", cyc,
                     xbus_addr_a, xbus_be_a, xbus_we_a, xbus_wdata_a);
            check("beat_addr", xbus_addr_a, cur.addr);
            check("beat_be", {28'b0, xbus_be_a}, {28'b0, cur.be});
            check("beat_we", {31'b0, xbus_we_a}, {31'b0, cur.we});
            if (cur.we) check("beat_wdata", xbus_wdata_a, cur.wdata);
          end
        end
        if (busy) begin
          if (wcnt == cur.waits) begin
            xbus_ack_a   = 1'b1;
            xbus_rdata_a = cur.rdata;
            xbus_err_a   = cur.err;
            busy         = 1'b0;
          end else begin
            wcnt++;
          end
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, expected to finish", $time);
    $fatal(1, "timeout");
  end

  initial begin : stim
    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_req_ready", {31'b0, req_ready_a}, 32'd1);
    check("rst_resp_valid", {31'b0, resp_valid_a}, 32'd0);
    check("rst_resp_err", {31'b0, resp_err_a}, 32'd0);
    check("rst_resp_rdata", resp_rdata_a, 32'h0);
    check("rst_xbus_req", {31'b0, xbus_req_a}, 32'd0);
    check("rst_xbus_we", {31'b0, xbus_we_a}, 32'd0);
    check("rst_xbus_be", {28'b0, xbus_be_a}, 32'd0);
    check("rst_xbus_addr", xbus_addr_a, 32'h0);
    check("rst_xbus_wdata", xbus_wdata_a, 32'h0);
    rst = 1'b0;

    // Aligned loads and sub-word extension.
    push_beat(32'h100, 4'b1111, 1'b0, 32'h0, 0, 32'hDEADBEEF, 1'b0);
    issue(0, 1'b0, 3'b010, 32'h100, 32'h0, 2, 32'hDEADBEEF, 1'b0, "lw_100");
    push_beat(32'h100, 4'b1000, 1'b0, 32'h0, 0, 32'h80123456, 1'b0);
    issue(0, 1'b0, 3'b000, 32'h103, 32'h0, 2, 32'hFFFFFF80, 1'b0, "lb_103");
    push_beat(32'h100, 4'b1000, 1'b0, 32'h0, 0, 32'h80123456, 1'b0);
    issue(0, 1'b0, 3'b100, 32'h103, 32'h0, 2, 32'h00000080, 1'b0, "lbu_103");
    push_beat(32'h100, 4'b1100, 1'b0, 32'h0, 1, 32'hBEEF0000, 1'b0);
    issue(0, 1'b0, 3'b101, 32'h102, 32'h0, 3, 32'h0000BEEF, 1'b0, "lhu_102_wait1");
    push_beat(32'h100, 4'b0010, 1'b1, 32'h3456A500, 0, 32'h0, 1'b0);
    issue(0, 1'b1, 3'b000, 32'h101, 32'h123456A5, 2, 32'h0, 1'b0, "sb_101");

    // Split accesses.
    push_beat(32'h100, 4'b1100, 1'b1, 32'hCCDD0000, 0, 32'h0, 1'b0);
    push_beat(32'h104, 4'b0011, 1'b1, 32'h0000AABB, 0, 32'h0, 1'b0);
    issue(0, 1'b1, 3'b010, 32'h102, 32'hAABBCCDD, 3, 32'h0, 1'b0, "sw_102_split");
    push_beat(32'h100, 4'b1000, 1'b0, 32'h0, 0, 32'h34000000, 1'b0);
    push_beat(32'h104, 4'b0001, 1'b0, 32'h0, 2, 32'h00000092, 1'b0);
    issue(0, 1'b0, 3'b001, 32'h103, 32'h0, 5, 32'hFFFF9234, 1'b0, "lh_103_split");
    push_beat(32'hFFFFFFFC, 4'b1100, 1'b1, 32'h33440000, 0, 32'h0, 1'b0);
    push_beat(32'h00000000, 4'b0011, 1'b1, 32'h00001122, 0, 32'h0, 1'b0);
    issue(0, 1'b1, 3'b010, 32'hFFFFFFFE, 32'h11223344, 3, 32'h0, 1'b0, "sw_wrap");

    // Errors: illegal length, bus error on beat0 of a split.
    issue(0, 1'b0, 3'b011, 32'h100, 32'h0, 1, 32'h0, 1'b1, "ld_dbl_a");
    push_beat(32'h100, 4'b1100, 1'b0, 32'h0, 0, 32'hFFFFFFFF, 1'b1);
    issue(0, 1'b0, 3'b010, 32'h102, 32'h0, 2, 32'h0, 1'b1, "lw_102_buserr");

    // Rejecting unit.
    issue(1, 1'b0, 3'b010, 32'h101, 32'h0, 1, 32'h0, 1'b1, "lw_101_reject");
    issue(1, 1'b0, 3'b011, 32'h100, 32'h0, 1, 32'h0, 1'b1, "ld_dbl_b");
    issue(1, 1'b0, 3'b010, 32'h200, 32'h0, 2, 32'h12345678, 1'b0, "lw_200_b");
    issue(1, 1'b0, 3'b101, 32'h102, 32'h0, 2, 32'h00001234, 1'b0, "lhu_102_b");

    // Reset while waiting in beat1.
    push_beat(32'h100, 4'b1000, 1'b0, 32'h0, 0, 32'h0, 1'b0);
    push_beat(32'h104, 4'b0001, 1'b0, 32'h0, 20, 32'h0, 1'b0);
    issue(0, 1'b0, 3'b001, 32'h103, 32'h0, -1, 32'h0, 1'b0, "lh_rst");
    @(negedge clk);
    @(negedge clk);
    check("rst_mid_req_before", {31'b0, xbus_req_a}, 32'd1);
    #2 rst = 1'b1;
    #1;
    check("rst_mid_req_drop", {31'b0, xbus_req_a}, 32'd0);
    check("rst_mid_resp_valid", {31'b0, resp_valid_a}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_mid_ready", {31'b0, req_ready_a}, 32'd1);

    // Normal operation after the abandoned beat.
    push_beat(32'h200, 4'b1111, 1'b0, 32'h0, 0, 32'h0BADF00D, 1'b0);
    issue(0, 1'b0, 3'b010, 32'h200, 32'h0, 2, 32'h0BADF00D, 1'b0, "lw_after_rst");

    for (int i = 0; i < 50 && (exp_a.size() != 0 || exp_b.size() != 0); i++) @(negedge clk);
    repeat (2) @(negedge clk);
    check("pending_resp_a", 32'(exp_a.size()), 32'd0);
    check("pending_resp_b", 32'(exp_b.size()), 32'd0);
    check("pending_beats", 32'(beat_q.size()), 32'd0);
    check("beats_b", 32'(breq_b_cnt), 32'd2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
